tree_add_pipe: RTL and testbench

Pipelined, flow-controlled successor to the combinational tree adder. It reduces T lanes of WIDTH-bit coefficients, either as a sum across lanes accumulated over a multi-beat burst or as a lane-wise a+b. It sits between the matrix-multiply datapath and the packing/encoding stages. Each input beat carries its own mode and security level, so mixed traffic streams through without draining the pipeline.

---
 rtl/tree_add_pipe_pkg.sv | 30 +++
 rtl/tree_add_pipe_if.sv | 30 +++
 rtl/tree_add_pipe_level.sv | 42 ++++
 rtl/tree_add_pipe.sv | 197 +++++++++++++++++++
 tb/tb_tree_add_pipe.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tree_add_pipe_pkg.sv
// Shared types and constants for the pipelined tree adder.
package tree_add_pkg;

  localparam logic [2:0] SEC_LEV_1 = 3'd1;
  localparam logic [2:0] SEC_LEV_3 = 3'd3;
  localparam logic [2:0] SEC_LEV_5 = 3'd5;

  localparam logic MODE_REDUCE = 1'b0;
  localparam logic MODE_LANE   = 1'b1;

  // Per-beat control that travels alongside the data through every stage.
  typedef struct packed {
    logic       valid;
    logic       mode;
    logic [2:0] sec_lev;
    logic       first;
    logic       last;
  } sideband_t;

  // Ceiling log2, used to size the tree depth at elaboration time.
  function automatic int CLOG2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      r = ((32'sd1 << i) < n) ? (i + 1) : r;
    end
    return r;
  endfunction

endpackage

// File: rtl/tree_add_pipe_if.sv
// Beat-level stream interface of the tree adder: input beat, output beat, handshakes.
interface tree_add_pipe_if #(
  parameter int T     = 16,
  parameter int WIDTH = 16
);
  logic [2:0]         i_sec_lev;
  logic               i_mode;
  logic               i_first;
  logic               i_last;
  logic               i_valid;
  logic               o_ready;
  logic [T*WIDTH-1:0] i_a;
  logic [T*WIDTH-1:0] i_b;
  logic [T*WIDTH-1:0] i_array;
  logic               o_valid;
  logic               i_ready;
  logic               o_mode;
  logic [WIDTH-1:0]   o_element;
  logic [T*WIDTH-1:0] o_array;

  modport master (
    output i_sec_lev, i_mode, i_first, i_last, i_valid, i_a, i_b, i_array, i_ready,
    input  o_ready, o_valid, o_mode, o_element, o_array
  );

  modport slave (
    input  i_sec_lev, i_mode, i_first, i_last, i_valid, i_a, i_b, i_array, i_ready,
    output o_ready, o_valid, o_mode, o_element, o_array
  );
endinterface

// File: rtl/tree_add_pipe_level.sv
// One registered level of the adder tree. PASS=0 adds neighbouring lane pairs
// (IN_LANES -> IN_LANES/2); PASS=1 is a plain delay stage of the same shape.
module tree_add_level #(
  parameter int IN_LANES = 2,
  parameter int WIDTH    = 16,
  parameter bit PASS     = 1'b0
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic                                                en,
  input  logic [IN_LANES*WIDTH-1:0]                           in_data,
  output logic [(PASS ? IN_LANES : IN_LANES/2)*WIDTH-1:0]     out_data
);
  localparam int OUT_LANES = PASS ? IN_LANES : IN_LANES / 2;

  logic [OUT_LANES*WIDTH-1:0] sum_s;

  if (PASS) begin : g_pass
    assign sum_s = in_data;
  end else begin : g_add
    // Pairwise lane sums, wrapping mod 2^WIDTH.
    always_comb begin
      sum_s = '0;
      for (int j = 0; j < OUT_LANES; j++) begin
        sum_s[j*WIDTH +: WIDTH] = in_data[(2*j)*WIDTH +: WIDTH]
                                + in_data[(2*j+1)*WIDTH +: WIDTH];
      end
    end
  end

  // Level register; holds while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data <= '0;
    end else if (en) begin
      out_data <= sum_s;
    end else begin
      out_data <= out_data;
    end
  end

endmodule

// File: rtl/tree_add_pipe.sv
// Pipelined, flow-controlled tree adder: reduce-with-accumulate or lane-wise a+b,
// both modes sharing one latency of LOG_T+1 cycles so beat order is preserved.
module tree_add_pipe
  import tree_add_pkg::*;
#(
  parameter int T      = 16,
  parameter int WIDTH  = 16,
  parameter bit ACC_EN = 1'b1
) (
  input logic            i_clk,
  input logic            i_rst_n,
  tree_add_pipe_if.slave bus
);
  localparam int LOG_T = CLOG2(T);
  localparam int NODES = 2 * T - 1;

  logic                       stall_s;
  logic                       adv_s;
  // Heap-style storage: level l input lanes start at 2T - 2*(T>>l); final sum is the last lane.
  logic [NODES*WIDTH-1:0]     node_s;
  logic [2*T*WIDTH-1:0]       ab_s;
  logic [LOG_T*T*WIDTH-1:0]   lane_pipe_s;
  logic [T*WIDTH-1:0]         lane_sum_s;
  logic [T*WIDTH-1:0]         lane_mask_s;
  logic [WIDTH-1:0]           tree_sum_s;
  logic [WIDTH-1:0]           acc_next_s;
  sideband_t                  in_sb_s;
  sideband_t                  out_sb_s;
  sideband_t                  sb_r [LOG_T];
  logic [WIDTH-1:0]           acc_r;
  logic                       open_r;
  logic                       o_valid_r;
  logic                       o_mode_r;
  logic [WIDTH-1:0]           o_element_r;
  logic [T*WIDTH-1:0]         o_array_r;

  // Clears the MSB for the lowest security level; internal sums stay full width.
  function automatic logic [WIDTH-1:0] mask_msb(input logic [WIDTH-1:0] value,
                                                input logic [2:0] sec_lev);
    logic [WIDTH-1:0] res;
    res = value;
    if (sec_lev == SEC_LEV_1) begin
      res[WIDTH-1] = 1'b0;
    end else begin
      res[WIDTH-1] = value[WIDTH-1];
    end
    return res;
  endfunction

  assign stall_s       = o_valid_r & ~bus.i_ready;
  assign adv_s         = ~stall_s;
  assign bus.o_ready   = adv_s;
  assign bus.o_valid   = o_valid_r;
  assign bus.o_mode    = o_mode_r;
  assign bus.o_element = o_element_r;
  assign bus.o_array   = o_array_r;

  // ---------------- reduce tree ----------------
  assign node_s[T*WIDTH-1:0] = bus.i_array;

  for (genvar l = 0; l < LOG_T; l++) begin : g_tree
    localparam int IN_L     = T >> l;
    localparam int IN_BASE  = 2 * T - 2 * IN_L;
    localparam int OUT_BASE = IN_BASE + IN_L;
    tree_add_level #(.IN_LANES(IN_L), .WIDTH(WIDTH), .PASS(1'b0)) u_level (
      .clk      (i_clk),
      .rst_n    (i_rst_n),
      .en       (adv_s),
      .in_data  (node_s[IN_BASE*WIDTH +: IN_L*WIDTH]),
      .out_data (node_s[OUT_BASE*WIDTH +: (IN_L/2)*WIDTH])
    );
  end

  assign tree_sum_s = node_s[(NODES-1)*WIDTH +: WIDTH];

  // ---------------- lane-wise path ----------------
  // Interleave a/b so the first pairwise level forms a[k]+b[k].
  always_comb begin
    ab_s = '0;
    for (int k = 0; k < T; k++) begin
      ab_s[(2*k)*WIDTH +: WIDTH]   = bus.i_a[k*WIDTH +: WIDTH];
      ab_s[(2*k+1)*WIDTH +: WIDTH] = bus.i_b[k*WIDTH +: WIDTH];
    end
  end

  tree_add_level #(.IN_LANES(2*T), .WIDTH(WIDTH), .PASS(1'b0)) u_lane_add (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .en       (adv_s),
    .in_data  (ab_s),
    .out_data (lane_pipe_s[0 +: T*WIDTH])
  );

  for (genvar j = 1; j < LOG_T; j++) begin : g_delay
    tree_add_level #(.IN_LANES(T), .WIDTH(WIDTH), .PASS(1'b1)) u_delay (
      .clk      (i_clk),
      .rst_n    (i_rst_n),
      .en       (adv_s),
      .in_data  (lane_pipe_s[(j-1)*T*WIDTH +: T*WIDTH]),
      .out_data (lane_pipe_s[j*T*WIDTH +: T*WIDTH])
    );
  end

  assign lane_sum_s = lane_pipe_s[(LOG_T-1)*T*WIDTH +: T*WIDTH];

  // ---------------- sideband ----------------
  // Without accumulation every reduce beat is a complete burst on its own.
  always_comb begin
    in_sb_s.valid   = bus.i_valid;
    in_sb_s.mode    = bus.i_mode;
    in_sb_s.sec_lev = bus.i_sec_lev;
    if (!ACC_EN && (bus.i_mode == MODE_REDUCE)) begin
      in_sb_s.first = 1'b1;
      in_sb_s.last  = 1'b1;
    end else begin
      in_sb_s.first = bus.i_first;
      in_sb_s.last  = bus.i_last;
    end
  end

  // Sideband delay line, one entry per tree level.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int j = 0; j < LOG_T; j++) begin
        sb_r[j] <= '0;
      end
    end else if (adv_s) begin
      sb_r[0] <= in_sb_s;
      for (int j = 1; j < LOG_T; j++) begin
        sb_r[j] <= sb_r[j-1];
      end
    end else begin
      for (int j = 0; j < LOG_T; j++) begin
        sb_r[j] <= sb_r[j];
      end
    end
  end

  assign out_sb_s = sb_r[LOG_T-1];

  // ---------------- accumulator and output ----------------
  // A first beat, or any beat with no burst open, restarts the accumulation.
  always_comb begin
    if (out_sb_s.first || !open_r) begin
      acc_next_s = tree_sum_s;
    end else begin
      acc_next_s = acc_r + tree_sum_s;
    end
  end

  // Per-lane MSB masking of the lane-wise result.
  always_comb begin
    lane_mask_s = '0;
    for (int k = 0; k < T; k++) begin
      lane_mask_s[k*WIDTH +: WIDTH] = mask_msb(lane_sum_s[k*WIDTH +: WIDTH], out_sb_s.sec_lev);
    end
  end

  // Accumulator state and registered output beat; frozen during a stall.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      acc_r       <= '0;
      open_r      <= 1'b0;
      o_valid_r   <= 1'b0;
      o_mode_r    <= MODE_REDUCE;
      o_element_r <= '0;
      o_array_r   <= '0;
    end else if (adv_s) begin
      if (out_sb_s.valid) begin
        case (out_sb_s.mode)
          MODE_REDUCE: begin
            acc_r <= acc_next_s;
            if (out_sb_s.last) begin
              open_r      <= 1'b0;
              o_valid_r   <= 1'b1;
              o_mode_r    <= MODE_REDUCE;
              o_element_r <= mask_msb(acc_next_s, out_sb_s.sec_lev);
            end else begin
              open_r    <= 1'b1;
              o_valid_r <= 1'b0;
            end
          end
          default: begin
            o_valid_r <= 1'b1;
            o_mode_r  <= MODE_LANE;
            o_array_r <= lane_mask_s;
          end
        endcase
      end else begin
        o_valid_r <= 1'b0;
      end
    end else begin
      o_valid_r <= o_valid_r;
    end
  end

endmodule

// File: tb/tb_tree_add_pipe.sv
// Directed bench for tree_add_pipe: table of single-beat vectors plus
// hand-written multi-beat, backpressure and reset sequences.
module tb_tree_add_pipe;
  import tree_add_pkg::*;

  localparam int T  = 16;
  localparam int W  = 16;
  localparam int AW = T * W;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tree_add_pipe_if #(.T(T), .WIDTH(W)) bus ();

  tree_add_pipe #(.T(T), .WIDTH(W), .ACC_EN(1'b1)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    string       name;
    logic        mode;
    logic [2:0]  sec;
    logic [AW-1:0] arr;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [15:0] exp_el;
    logic [15:0] exp_l0;
    logic [15:0] exp_l5;
  } vec_t;

  vec_t vecs[6];

  logic          seq_mode  [8];
  logic [2:0]    seq_sec   [8];
  logic          seq_first [8];
  logic          seq_last  [8];
  logic [AW-1:0] seq_arr   [8];
  logic [AW-1:0] seq_a     [8];
  logic [AW-1:0] seq_b     [8];

  int          out_cnt;
  logic        out_mode [8];
  logic [15:0] out_el   [8];
  logic [15:0] out_l0   [8];
  logic [15:0] out_l5   [8];
  int          out_cyc  [8];

  function automatic logic [AW-1:0] fill_lanes(input logic [15:0] v);
    logic [AW-1:0] r;
    for (int k = 0; k < T; k++) r[k*W +: W] = v;
    return r;
  endfunction

  function automatic logic [AW-1:0] ramp(input logic [15:0] start);
    logic [AW-1:0] r;
    for (int k = 0; k < T; k++) r[k*W +: W] = start + 16'(k);
    return r;
  endfunction

  function automatic vec_t mk_vec(input string name, input logic mode, input logic [2:0] sec,
                                  input logic [AW-1:0] arr, input logic [AW-1:0] a,
                                  input logic [AW-1:0] b, input logic [15:0] el,
                                  input logic [15:0] l0, input logic [15:0] l5);
    vec_t v;
    v.name = name; v.mode = mode; v.sec = sec; v.arr = arr; v.a = a; v.b = b;
    v.exp_el = el; v.exp_l0 = l0; v.exp_l5 = l5;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_beat(input int i, input logic mode, input logic [2:0] sec, input logic first,
                          input logic last, input logic [AW-1:0] arr, input logic [AW-1:0] a,
                          input logic [AW-1:0] b);
    seq_mode[i] = mode; seq_sec[i] = sec; seq_first[i] = first; seq_last[i] = last;
    seq_arr[i] = arr; seq_a[i] = a; seq_b[i] = b;
  endtask

  task automatic drive_beat(input int i);
    bus.i_mode    = seq_mode[i];
    bus.i_sec_lev = seq_sec[i];
    bus.i_first   = seq_first[i];
    bus.i_last    = seq_last[i];
    bus.i_array   = seq_arr[i];
    bus.i_a       = seq_a[i];
    bus.i_b       = seq_b[i];
    bus.i_valid   = 1'b1;
  endtask

  // Drives n beats back to back (i_ready high) and records every output beat;
  // out_cyc counts clock edges, the first beat being accepted on edge 1.
  task automatic run_seq(input int n);
    out_cnt = 0;
    for (int k = 0; k < 8; k++) out_cyc[k] = 0;
    for (int c = 0; c < n + 12; c++) begin
      if (c < n) drive_beat(c);
      else bus.i_valid = 1'b0;
      @(posedge clk); #1;
      if (bus.o_valid) begin
        if (out_cnt < 8) begin
          out_mode[out_cnt] = bus.o_mode;
          out_el[out_cnt]   = bus.o_element;
          out_l0[out_cnt]   = bus.o_array[0 +: W];
          out_l5[out_cnt]   = bus.o_array[5*W +: W];
          out_cyc[out_cnt]  = c + 1;
        end
        out_cnt++;
      end
    end
  endtask

  task automatic bp_drive(input int idx);
    bus.i_mode    = MODE_REDUCE;
    bus.i_sec_lev = SEC_LEV_3;
    bus.i_first   = 1'b1;
    bus.i_last    = 1'b1;
    bus.i_array   = '0;
    bus.i_array[15:0] = 16'(idx + 1);
    bus.i_a       = '0;
    bus.i_b       = '0;
    bus.i_valid   = 1'b1;
  endtask

  initial begin
    logic [AW-1:0] zero_v;
    int  idx_in;
    int  got;
    int  extra;
    logic in_fire;
    logic out_fire;

    zero_v = '0;
    rst_n = 1'b0;
    bus.i_sec_lev = 3'd0; bus.i_mode = 1'b0; bus.i_first = 1'b0; bus.i_last = 1'b0;
    bus.i_valid = 1'b0; bus.i_ready = 1'b1;
    bus.i_a = '0; bus.i_b = '0; bus.i_array = '0;

    vecs[0] = mk_vec("red_ramp_s3",  MODE_REDUCE, SEC_LEV_3, ramp(16'd1), zero_v, zero_v,
                     16'h0088, 16'h0, 16'h0);
    vecs[1] = mk_vec("red_0800_s1",  MODE_REDUCE, SEC_LEV_1, fill_lanes(16'h0800), zero_v, zero_v,
                     16'h0000, 16'h0, 16'h0);
    vecs[2] = mk_vec("red_0800_s3",  MODE_REDUCE, SEC_LEV_3, fill_lanes(16'h0800), zero_v, zero_v,
                     16'h8000, 16'h0, 16'h0);
    vecs[3] = mk_vec("lane_s5",      MODE_LANE, SEC_LEV_5, zero_v, ramp(16'd0), fill_lanes(16'hFFFF),
                     16'h0, 16'hFFFF, 16'h0004);
    vecs[4] = mk_vec("lane_s1",      MODE_LANE, SEC_LEV_1, zero_v, ramp(16'd0), fill_lanes(16'hFFFF),
                     16'h0, 16'h7FFF, 16'h0004);
    vecs[5] = mk_vec("red_ffff_s1",  MODE_REDUCE, SEC_LEV_1, fill_lanes(16'hFFFF), zero_v, zero_v,
                     16'h7FF0, 16'h0, 16'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_o_valid",   32'(bus.o_valid), 32'd0);
    chk("rst_o_mode",    32'(bus.o_mode), 32'd0);
    chk("rst_o_element", 32'(bus.o_element), 32'd0);
    chk("rst_o_array",   32'(bus.o_array == zero_v), 32'd1);
    chk("rst_o_ready",   32'(bus.o_ready), 32'd1);
    rst_n = 1'b1;

    // Single-beat vectors.
    for (int i = 0; i < 6; i++) begin
      set_beat(0, vecs[i].mode, vecs[i].sec, 1'b1, 1'b1, vecs[i].arr, vecs[i].a, vecs[i].b);
      run_seq(1);
      chk({vecs[i].name, "_count"}, 32'(out_cnt), 32'd1);
      chk({vecs[i].name, "_latency"}, 32'(out_cyc[0]), 32'd5);
      chk({vecs[i].name, "_mode"}, 32'(out_mode[0]), 32'(vecs[i].mode));
      if (vecs[i].mode == MODE_REDUCE) begin
        chk({vecs[i].name, "_element"}, 32'(out_el[0]), 32'(vecs[i].exp_el));
      end else begin
        chk({vecs[i].name, "_lane0"}, 32'(out_l0[0]), 32'(vecs[i].exp_l0));
        chk({vecs[i].name, "_lane5"}, 32'(out_l5[0]), 32'(vecs[i].exp_l5));
      end
    end

    // Three-beat accumulation: 3 x 0x1000.
    set_beat(0, MODE_REDUCE, SEC_LEV_5, 1'b1, 1'b0, fill_lanes(16'h0100), zero_v, zero_v);
    set_beat(1, MODE_REDUCE, SEC_LEV_5, 1'b0, 1'b0, fill_lanes(16'h0100), zero_v, zero_v);
    set_beat(2, MODE_REDUCE, SEC_LEV_5, 1'b0, 1'b1, fill_lanes(16'h0100), zero_v, zero_v);
    run_seq(3);
    chk("acc3_count",   32'(out_cnt), 32'd1);
    chk("acc3_element", 32'(out_el[0]), 32'h3000);
    chk("acc3_cycle",   32'(out_cyc[0]), 32'd7);

    // Lane-wise beat inside an open reduce burst: 0x1000 + 0x0100.
    set_beat(0, MODE_REDUCE, SEC_LEV_3, 1'b1, 1'b0, fill_lanes(16'h0100), zero_v, zero_v);
    set_beat(1, MODE_LANE,   SEC_LEV_3, 1'b0, 1'b0, zero_v, ramp(16'd0), fill_lanes(16'h0001));
    set_beat(2, MODE_REDUCE, SEC_LEV_3, 1'b0, 1'b1, fill_lanes(16'h0010), zero_v, zero_v);
    run_seq(3);
    chk("ilv_count",      32'(out_cnt), 32'd2);
    chk("ilv_lane_mode",  32'(out_mode[0]), 32'd1);
    chk("ilv_lane5",      32'(out_l5[0]), 32'h0006);
    chk("ilv_red_mode",   32'(out_mode[1]), 32'd0);
    chk("ilv_red_element", 32'(out_el[1]), 32'h1100);

    // Repeated first restarts; a last followed directly by a first has no bubble.
    set_beat(0, MODE_REDUCE, SEC_LEV_3, 1'b1, 1'b0, fill_lanes(16'h0100), zero_v, zero_v);
    set_beat(1, MODE_REDUCE, SEC_LEV_3, 1'b1, 1'b1, fill_lanes(16'h0010), zero_v, zero_v);
    set_beat(2, MODE_REDUCE, SEC_LEV_3, 1'b1, 1'b1, fill_lanes(16'h0002), zero_v, zero_v);
    run_seq(3);
    chk("restart_count",   32'(out_cnt), 32'd2);
    chk("restart_element", 32'(out_el[0]), 32'h0100);
    chk("restart_cycle",   32'(out_cyc[0]), 32'd6);
    chk("nobubble_element", 32'(out_el[1]), 32'h0020);
    chk("nobubble_cycle",  32'(out_cyc[1]), 32'd7);

    // Backpressure: 20 single-beat reductions, i_ready low on cycles 8..11.
    idx_in = 0;
    got    = 0;
    bp_drive(0);
    for (int cyc = 0; cyc < 80 && got < 20; cyc++) begin
      bus.i_ready = !(cyc >= 8 && cyc < 12);
      #1;
      if (cyc >= 8 && cyc < 12) chk("bp_o_ready_low", 32'(bus.o_ready), 32'd0);
      out_fire = bus.o_valid && bus.i_ready;
      in_fire  = bus.i_valid && bus.o_ready;
      if (out_fire) begin
        chk("bp_order", 32'(bus.o_element), 32'(got + 1));
        got++;
      end
      @(posedge clk); #1;
      if (in_fire) begin
        idx_in++;
        if (idx_in < 20) bp_drive(idx_in);
        else bus.i_valid = 1'b0;
      end
    end
    bus.i_ready = 1'b1;
    bus.i_valid = 1'b0;
    chk("bp_count", 32'(got), 32'd20);
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (bus.o_valid) extra++;
    end
    chk("bp_no_duplicates", 32'(extra), 32'd0);

    // Reset after 2 of 4 burst beats.
    set_beat(0, MODE_REDUCE, SEC_LEV_3, 1'b1, 1'b0, fill_lanes(16'h0001), zero_v, zero_v);
    set_beat(1, MODE_REDUCE, SEC_LEV_3, 1'b0, 1'b0, fill_lanes(16'h0001), zero_v, zero_v);
    drive_beat(0);
    @(posedge clk); #1;
    drive_beat(1);
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_o_valid",   32'(bus.o_valid), 32'd0);
    chk("midrst_o_element", 32'(bus.o_element), 32'd0);
    chk("midrst_o_array",   32'(bus.o_array == zero_v), 32'd1);
    chk("midrst_o_mode",    32'(bus.o_mode), 32'd0);
    rst_n = 1'b1;
    set_beat(0, MODE_REDUCE, SEC_LEV_3, 1'b0, 1'b1, fill_lanes(16'h0001), zero_v, zero_v);
    set_beat(1, MODE_REDUCE, SEC_LEV_3, 1'b1, 1'b1, fill_lanes(16'h0001), zero_v, zero_v);
    run_seq(2);
    chk("postrst_count",    32'(out_cnt), 32'd2);
    chk("postrst_closed",   32'(out_el[0]), 32'd16);
    chk("postrst_cycle",    32'(out_cyc[0]), 32'd5);
    chk("postrst_fresh",    32'(out_el[1]), 32'd16);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
